register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
- Parametrised successor to the core's 32x32 register file: configurable data width and depth.
- Two asynchronous read ports and one synchronous write port.
- Write-to-read bypass, a hardware init sequencer that replaces simulation-only initial values, and a per-register busy scoreboard for the pipelined RISC-V datapath.
- Sits between decode (read/scoreboard issue) and writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, index width; DEPTH = 2**ADDR_WIDTH registers.
- SP_INDEX, 2, register loaded with SP_INIT during init.
- SP_INIT, 32'h7fffefe4, init value of SP_INDEX (truncated/zero-extended to DATA_WIDTH).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  writeback write enable.
- wa  in  ADDR_WIDTH  writeback address.
- wd  in  DATA_WIDTH  writeback data.
- ra1  in  ADDR_WIDTH  read port 1 address.
- ra2  in  ADDR_WIDTH  read port 2 address.
- rd1  out  DATA_WIDTH  read port 1 data (combinational).
- rd2  out  DATA_WIDTH  read port 2 data (combinational).
- sb_set  in  1  decode issued an instruction writing sb_addr.
- sb_addr  in  ADDR_WIDTH  destination register being issued.
- busy1  out  1  ra1 has a pending (unwritten) producer.
- busy2  out  1  ra2 has a pending producer.
- init_busy  out  1  init sequencer running; pipeline must stall.

Behaviour:
- Reset (rst_n low, async): FSM = INIT, init counter = 0, busy vector cleared. Outputs during reset: init_busy=1, rd1=rd2=0, busy1=busy2=0.
- FSM states: INIT, RUN.
  - INIT: each cycle writes reg[cnt] = (cnt==SP_INDEX) ? SP_INIT : 0, then cnt++. After writing cnt==DEPTH-1, go to RUN.
  - INIT lasts exactly DEPTH cycles after rst_n rises; init_busy deasserts on the cycle RUN is entered.
  - RUN: stays in RUN until reset.
- During INIT:
  - we and sb_set are ignored (no array write, no scoreboard change).
  - rd1/rd2 forced to 0; busy1/busy2 forced to 0.
- Register 0 is hardwired zero:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
  - sb_set to address 0 is ignored; busy for address 0 is always 0.
- Write (RUN): on clk rise with we=1 and wa!=0, reg[wa] <= wd.
- Read: rdN = (we && wa==raN && wa!=0) ? wd : reg[raN]. Same-cycle write data is visible with zero latency (write-first bypass). Both ports may bypass simultaneously.
- Scoreboard (RUN), per register:
  - sb_set with sb_addr=k sets busy[k] at the next edge.
  - we with wa=k clears busy[k] at the next edge.
  - Simultaneous set and clear of the same k: set wins (a newer producer was issued).
  - Different addresses in the same cycle: both updates apply.
  - Setting an already-busy entry keeps it set.
- busyN = busy[raN] & ~(we && wa==raN). The bypass makes the value available this cycle, so the stall is suppressed.
- Reset mid-INIT or mid-RUN: immediate return to INIT with cnt=0 and busy cleared. Array contents are don't-care until re-init completes.
- Width rules: wd stored as-is. No sign handling inside the block.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- Defined: adds input dbg_addr [ADDR_WIDTH] and output dbg_data [DATA_WIDTH].
  - dbg_data = reg[dbg_addr], combinational, no bypass.
  - Also adds output dbg_busy_vec [DEPTH], the raw scoreboard vector.
  - Intended for the on-chip logic analyser in place of hand-wired taps.
  - Forced to 0 during INIT.
- Not defined: ports absent; no extra logic. Behaviour otherwise identical.

Test Plan:
- Init: release rst_n, hold ra1=2, ra2=5.
  - init_busy=1 for exactly 32 cycles.
  - Then rd1=32'h7fffefe4, rd2=0, busy1=busy2=0.
- Write/read and x0: after init, write we=1 wa=7 wd=32'hDEADBEEF.
  - Next cycle ra1=7 gives rd1=32'hDEADBEEF.
  - Write wa=0 wd=32'h1234; ra2=0 reads 0, including in the same cycle as the write.
- Bypass: we=1 wa=9 wd=32'hA5A5A5A5 with ra1=ra2=9 in the same cycle.
  - rd1=rd2=32'hA5A5A5A5 combinationally, before the clock edge.
- Scoreboard:
  - sb_set sb_addr=12, then ra1=12 → busy1=1.
  - we wa=12 same cycle → busy1=0 and rd1=wd.
  - Next cycle busy1=0.
  - sb_set=1 sb_addr=12 with we=1 wa=12 same cycle → busy1=1 the cycle after.
- Mid-operation reset: after writing reg[3]=32'h55, assert rst_n low for 2 cycles mid-RUN.
  - init_busy=1 immediately (async).
  - Busy vector cleared; after 32 cycles reg[3] reads 0.
- INIT ignores inputs: we=1 wa=4 wd=32'hFF and sb_set sb_addr=4 during INIT cycle 10.
  - After init, ra1=4 gives rd1=0 and busy1=0.

Source files
------------

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of register_file_sb: read ports, writeback port, scoreboard, init status.
// REGFILE_DBG_PORT_EN adds the logic-analyser debug taps.
interface register_file_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [ADDR_WIDTH-1:0] ra1;
  logic [ADDR_WIDTH-1:0] ra2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  sb_set;
  logic [ADDR_WIDTH-1:0] sb_addr;
  logic                  busy1;
  logic                  busy2;
  logic                  init_busy;
`ifdef REGFILE_DBG_PORT_EN
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic [DEPTH-1:0]      dbg_busy_vec;
`endif

  modport master (
    output we, wa, wd, ra1, ra2, sb_set, sb_addr,
`ifdef REGFILE_DBG_PORT_EN
    output dbg_addr,
    input  dbg_data, dbg_busy_vec,
`endif
    input  rd1, rd2, busy1, busy2, init_busy
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, sb_set, sb_addr,
`ifdef REGFILE_DBG_PORT_EN
    input  dbg_addr,
    output dbg_data, dbg_busy_vec,
`endif
    output rd1, rd2, busy1, busy2, init_busy
  );
endinterface

// File: rtl/register_file_sb.sv
// Parametrised register file: 2 async read ports with write-first bypass, 1 write port,
// hardware init sequencer and per-register busy scoreboard. Optional macro: REGFILE_DBG_PORT_EN.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned SP_INDEX   = 2,
  parameter logic [31:0] SP_INIT    = 32'h7fffefe4
) (
  input logic           clk,
  input logic           rst_n,
  register_file_sb_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [DATA_WIDTH-1:0] SP_VAL = DATA_WIDTH'(SP_INIT);
  localparam logic [ADDR_WIDTH-1:0] SP_IDX = ADDR_WIDTH'(SP_INDEX);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic running;
  logic wr_en;
  logic byp1, byp2;

  assign running = (state_q == ST_RUN);
  assign wr_en   = running && bus.we && (bus.wa != '0);
  assign byp1    = bus.we && (bus.wa == bus.ra1);
  assign byp2    = bus.we && (bus.wa == bus.ra2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!running) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  // Clear is applied before set so a newer producer issued in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[bus.wa] = 1'b0;
    if (running && bus.sb_set && (bus.sb_addr != '0)) busy_d[bus.sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array has no reset; the init sequencer rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (!running) begin
      mem_q[cnt_q] <= (cnt_q == SP_IDX) ? SP_VAL : '0;
    end else if (wr_en) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    if (running && (bus.ra1 != '0)) bus.rd1 = byp1 ? bus.wd : mem_q[bus.ra1];
    if (running && (bus.ra2 != '0)) bus.rd2 = byp2 ? bus.wd : mem_q[bus.ra2];
  end

  assign bus.busy1     = running && busy_q[bus.ra1] && !byp1;
  assign bus.busy2     = running && busy_q[bus.ra2] && !byp2;
  assign bus.init_busy = !running;

`ifdef REGFILE_DBG_PORT_EN
  assign bus.dbg_data     = running ? mem_q[bus.dbg_addr] : '0;
  assign bus.dbg_busy_vec = running ? busy_q : '0;
`endif

endmodule
